des_block_uart_tx: RTL and testbench

DES_BLOCK_UART_TX -- requirements
Module: des_block_uart_tx

---
 rtl/des_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/des_block_uart_tx.sv | 115 +++++++++++
 tb/tb_des_block_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES block transmit path.
package des_pkg;

  localparam int DES_BLOCK_W     = 64;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-boundary pulse generator: one-cycle tick every CLKS_PER_BIT cycles,
// realigned by restart so the first bit of a block gets its full width.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == '0);

  // NOTE: sequential state is written with <= so every register samples
  // the pre-edge values of its neighbours; = here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (restart || tick) cnt <= RELOAD;
    else                      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/des_block_uart_tx.sv
// Serialises a 64-bit DES block over an 8N1 UART line, MSB byte first,
// LSB bit first, with back-to-back frames inside a block.
module des_block_uart_tx
  import des_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 868,
  parameter int BYTES_PER_BLOCK = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DES_BLOCK_W-1:0] block_in,
  input  logic                   block_valid,
  output logic                   block_ready,
  output logic                   tx,
  output logic                   busy
);

  localparam int BYTE_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_BLOCK - 1);

  uart_tx_state_t         state, state_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [BYTE_W-1:0]      byte_idx, byte_idx_n;
  logic [DES_BLOCK_W-1:0] shreg, shreg_n;
  logic [7:0]             byte_sh, byte_sh_n;
  logic                   tx_n;
  logic                   tick;
  logic                   accept;

  assign block_ready = (state == IDLE) && !reset;
  assign busy        = (state != IDLE);
  assign accept      = block_valid && block_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .tick   (tick)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;
    byte_sh_n  = byte_sh;
    tx_n       = tx;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n    = START;
          shreg_n    = block_in;
          bit_idx_n  = '0;
          byte_idx_n = '0;
          tx_n       = 1'b0;
        end
      end
      START: if (tick) begin
        // Peel the next MSB byte into the byte shifter; first data bit is its LSB.
        state_n   = DATA;
        byte_sh_n = shreg[DES_BLOCK_W-1 -: 8];
        shreg_n   = shreg << 8;
        bit_idx_n = '0;
        tx_n      = shreg[DES_BLOCK_W-8];
      end
      DATA: if (tick) begin
        if (bit_idx == 3'd7) begin
          state_n   = STOP;
          bit_idx_n = '0;
          tx_n      = 1'b1;
        end else begin
          bit_idx_n = bit_idx + 3'd1;
          byte_sh_n = byte_sh >> 1;
          tx_n      = byte_sh[1];
        end
      end
      STOP: if (tick) begin
        if (byte_idx == LAST_BYTE) begin
          state_n    = IDLE;
          byte_idx_n = '0;
          tx_n       = 1'b1;
        end else begin
          state_n    = START;
          byte_idx_n = byte_idx + BYTE_W'(1);
          tx_n       = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      byte_sh  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shreg    <= shreg_n;
      byte_sh  <= byte_sh_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: tb/tb_des_block_uart_tx.sv
// Self-checking bench for des_block_uart_tx with a per-cycle line model
// derived from the 8N1 framing rules and a mid-bit UART decoder.
module tb_des_block_uart_tx;

  localparam int C     = 4;
  localparam int BPB   = 8;
  localparam int TOTAL = BPB * 10 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] block_in;
  logic        block_valid;
  logic        block_ready;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] last_dec [BPB];
  logic [9:0] last_frame0;
  int         last_waited;

  des_block_uart_tx #(
    .CLKS_PER_BIT   (C),
    .BYTES_PER_BLOCK(BPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .block_in   (block_in),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level k cycles after the acceptance edge.
  function automatic logic exp_line(input logic [63:0] blk, input int k);
    int         b;
    int         pos;
    logic [7:0] v;
    b   = k / (10 * C);
    pos = (k % (10 * C)) / C;
    v   = blk[63 - 8*b -: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return v[pos-1];
  endfunction

  // mode 0: drop valid after acceptance; 1: keep valid high and present next_blk;
  // 2: scramble block_in/block_valid throughout the transfer.
  task automatic run_block(input logic [63:0] blk, input int mode, input logic [63:0] next_blk);
    int mism, busy_bad, ready_bad, b, pos;
    mism = 0; busy_bad = 0; ready_bad = 0;
    block_in    = blk;
    block_valid = 1'b1;
    last_waited = 0;
    while (!block_ready && last_waited < 50) begin
      @(negedge clk);
      last_waited++;
    end
    if (!block_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      block_valid = 1'b0;
      return;
    end
    @(negedge clk);
    check("tx_low_at_plus1", {63'd0, tx}, 64'd0);
    for (int k = 0; k < TOTAL; k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== exp_line(blk, k)) mism++;
      if (busy !== 1'b1)           busy_bad++;
      if (block_ready !== 1'b0)    ready_bad++;
      if (k % C == C / 2) begin
        b   = k / (10 * C);
        pos = (k % (10 * C)) / C;
        if (pos >= 1 && pos <= 8) last_dec[b][pos-1] = tx;
        if (b == 0) last_frame0[pos] = tx;
      end
      case (mode)
        0: block_valid = 1'b0;
        1: begin block_valid = 1'b1; block_in = next_blk; end
        default: begin
          block_in    = {$urandom, $urandom};
          block_valid = 1'($urandom_range(0, 1));
        end
      endcase
    end
    @(negedge clk);
    check("line_waveform_mismatches", 64'(mism), 64'd0);
    check("busy_low_during_block", 64'(busy_bad), 64'd0);
    check("ready_high_during_block", 64'(ready_bad), 64'd0);
    for (int i = 0; i < BPB; i++)
      check($sformatf("decoded_byte%0d", i), {56'd0, last_dec[i]}, {56'd0, blk[63 - 8*i -: 8]});
    check("busy_after_block", {63'd0, busy}, 64'd0);
    check("ready_after_block", {63'd0, block_ready}, 64'd1);
    check("tx_idle_after_block", {63'd0, tx}, 64'd1);
    if (mode != 1) block_valid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] blk;
    int          mode;
    logic [7:0]  first_byte;
    logic [7:0]  last_byte;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int bad;
    vecs[0] = '{64'h0123456789ABCDEF, 0, 8'h01, 8'hEF};
    vecs[1] = '{64'h8000000000000001, 0, 8'h80, 8'h01};
    vecs[2] = '{64'hDEADBEEFCAFEF00D, 2, 8'hDE, 8'h0D};
    vecs[3] = '{64'h5A0000000000003C, 2, 8'h5A, 8'h3C};

    reset       = 1'b1;
    block_in    = '0;
    block_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_tx", {63'd0, tx}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_ready", {63'd0, block_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {63'd0, block_ready}, 64'd1);

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].blk, vecs[i].mode, 64'd0);
      check($sformatf("vec%0d_first_byte", i), {56'd0, last_dec[0]}, {56'd0, vecs[i].first_byte});
      check($sformatf("vec%0d_last_byte", i), {56'd0, last_dec[BPB-1]}, {56'd0, vecs[i].last_byte});
    end

    // Byte 0x01 frame levels, start..stop (bit i = level of bit slot i).
    run_block(64'h0123456789ABCDEF, 0, 64'd0);
    check("frame_0x01_levels", {54'd0, last_frame0}, {54'd0, 10'b10_0000_0010});

    // Back-to-back with valid held high.
    run_block(64'hFFFFFFFFFFFFFFFF, 1, 64'h0000000000000000);
    run_block(64'h0000000000000000, 0, 64'd0);
    check("b2b_accept_wait_cycles", 64'(last_waited), 64'd0);

    // Reset at cycle 150 of a block.
    block_in    = 64'h1122334455667788;
    block_valid = 1'b1;
    bad = 0;
    while (!block_ready && bad < 50) begin @(negedge clk); bad++; end
    check("reset_test_accept", {63'd0, block_ready}, 64'd1);
    @(negedge clk);
    block_valid = 1'b0;
    for (int k = 1; k < 150; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_low_in_reset_cycle", {63'd0, block_ready}, 64'd0);
    @(negedge clk);
    check("midblock_reset_tx", {63'd0, tx}, 64'd1);
    check("midblock_reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    #1;
    check("midblock_reset_ready", {63'd0, block_ready}, 64'd1);
    run_block(64'hA5A5A5A5A5A5A5A5, 0, 64'd0);

    // Random blocks with input disturbance during transfer.
    for (int r = 0; r < 3; r++) run_block({$urandom, $urandom}, 2, 64'd0);

    // Idle line.
    block_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || block_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_1000_cycles_violations", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
